// File: rtl/br_pred_pkg.sv
// Shared definitions for the branch predictor: opcode, 2-bit counter
// encodings, recovery FSM states and the counter reset value.
package br_pred_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    localparam ctr_t CTR_RESET = WNT;

endpackage

// File: rtl/br_sat_counter.sv
// 2-bit saturating counter next-state function used on the table write path.
module br_sat_counter
    import br_pred_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    // Step toward strong-taken on a taken outcome, toward strong-not-taken otherwise.
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            case (ctr_i)
                SNT:     ctr_o = WNT;
                WNT:     ctr_o = WT;
                WT:      ctr_o = ST;
                default: ctr_o = ST;
            endcase
        end else begin
            case (ctr_i)
                ST:      ctr_o = WT;
                WT:      ctr_o = WNT;
                WNT:     ctr_o = SNT;
                default: ctr_o = SNT;
            endcase
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Dynamic branch predictor and misprediction-recovery controller.
// Optional statistics counters are enabled by defining BR_PRED_STATS_EN;
// without it the stat ports read 0 and no counter flops exist.
module branch_predict_ctrl
    import br_pred_pkg::*;
#(
    parameter int IDX_BITS = 4,
    parameter int PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] if_pc,
    input  logic [4:0]      if_op_code,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [4:0]      ex_op_code,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic            ex_branch,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_stall,
    output logic            flush,
    output logic            redirect,
    output logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_BITS;

    state_t              state_q;
    state_t              state_d;
    ctr_t                ctr_tbl [ENTRIES];
    ctr_t                rd_ctr;
    ctr_t                wr_cur;
    ctr_t                wr_ctr_d;
    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic                res;
    logic                mis;
    logic                unused_if_pc;

    assign rd_idx = if_pc[IDX_BITS+1:2];
    assign wr_idx = ex_pc[IDX_BITS+1:2];
    assign rd_ctr = ctr_tbl[rd_idx];
    assign wr_cur = ctr_tbl[wr_idx];

    // Only the index bits of the fetch PC select a counter.
    assign unused_if_pc = ^{if_pc[PC_W-1:IDX_BITS+2], if_pc[1:0]};

    // A branch resolves only when EX holds a real, unstalled branch outside recovery.
    assign res = ex_valid && (ex_op_code == OP_BRANCH) && !ex_stall && (state_q == RUN);
    assign mis = res && (ex_branch != ex_pred_taken);

    br_sat_counter u_sat (
        .ctr_i   (wr_cur),
        .taken_i (ex_branch),
        .ctr_o   (wr_ctr_d)
    );

    // One register per table entry; only the entry addressed by the resolving PC trains.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            localparam logic [IDX_BITS-1:0] MY_IDX = IDX_BITS'(gi);
            ctr_t entry_q;

            // Reset to weak-not-taken, then train on a resolve that hits this entry.
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_q <= CTR_RESET;
                end else if (res && (wr_idx == MY_IDX)) begin
                    entry_q <= wr_ctr_d;
                end
            end

            assign ctr_tbl[gi] = entry_q;
        end
    endgenerate

    // Recovery FSM state register; reset discards any pending recovery.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a mispredict spends exactly one cycle in RECOVER.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     state_d = mis ? RECOVER : RUN;
            RECOVER: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Outputs: prediction from the pre-update counter, flush/redirect on mispredict.
    always_comb begin
        pred_taken  = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if (!rst) begin
            pred_taken = (if_op_code == OP_BRANCH) && rd_ctr[1];
            if (mis) begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = ex_branch ? ex_target : (ex_pc + PC_W'(4));
            end
        end
    end

`ifdef BR_PRED_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mis_q;

    // Free-running, wrapping event counters for resolves and mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (res) stat_br_q  <= stat_br_q + 32'd1;
            if (mis) stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule
